// File: rtl/audio_vis_pkg.sv
// Constants and helpers shared by the volume history block and the bar renderer.
package audio_vis_pkg;

    localparam int SAMPLE_W    = 12;
    localparam int MAG_W       = 11;
    localparam int NUM_BARS    = 16;
    localparam int LEVEL_W     = 5;
    localparam int MAX_LEVEL   = 16;
    localparam int DC_OFFSET   = 2048;
    localparam int LEVEL_SHIFT = 7;

    localparam logic [SAMPLE_W-1:0] DC_CODE  = 12'd2048;
    localparam logic [SAMPLE_W-1:0] MAG_MAX  = 12'd2047;
    localparam logic [MAG_W:0]      LEVEL_RND = 12'd64;

    typedef logic [LEVEL_W-1:0] level_t;

    // Distance from mid-scale; code 0 is one step further than full positive swing, so clamp it.
    function automatic logic [MAG_W-1:0] sample_mag(input logic [SAMPLE_W-1:0] code);
        logic [SAMPLE_W-1:0] diff;
        if (code >= DC_CODE) begin
            diff = code - DC_CODE;
        end else begin
            diff = DC_CODE - code;
        end
        if (diff > MAG_MAX) begin
            diff = MAG_MAX;
        end else begin
            diff = diff;
        end
        return diff[MAG_W-1:0];
    endfunction

    function automatic level_t peak_to_level(input logic [MAG_W-1:0] pk);
        logic [MAG_W:0] sum;
        sum = {1'b0, pk} + LEVEL_RND;
        return sum[MAG_W:LEVEL_SHIFT];
    endfunction

endpackage

// File: rtl/volume_history_if.sv
// Sample stream in, bar heights and levels out.
interface volume_history_if;
    import audio_vis_pkg::*;

    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                freeze;
    level_t              volume [NUM_BARS];
    level_t              cur_level;
    level_t              hold_level;
    logic                level_valid;

    modport master (
        output sample_valid, sample, freeze,
        input  volume, cur_level, hold_level, level_valid
    );

    modport slave (
        input  sample_valid, sample, freeze,
        output volume, cur_level, hold_level, level_valid
    );

endinterface

// File: rtl/window_peak_detector.sv
// Tracks peak magnitude over WINDOW samples. The close strobe and level are combinational
// so the parent can register every output on the same edge that takes the last sample.
module window_peak_detector
    import audio_vis_pkg::*;
#(
    parameter int WINDOW = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                win_close,
    output level_t              win_level
);

    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WINDOW - 1);

    logic [CNT_W-1:0] count_r;
    logic [MAG_W-1:0] peak_r;
    logic [MAG_W-1:0] mag_s;
    logic [MAG_W-1:0] pk_s;

    // Peak including the current sample, and the level it would produce if the window closed now.
    always_comb begin
        mag_s     = sample_mag(sample);
        pk_s      = (mag_s > peak_r) ? mag_s : peak_r;
        win_close = sample_valid && (count_r == LAST_COUNT);
        win_level = peak_to_level(pk_s);
    end

    // Sample counter and running peak; both restart after the closing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            peak_r  <= {MAG_W{1'b0}};
        end else if (sample_valid) begin
            if (count_r == LAST_COUNT) begin
                count_r <= {CNT_W{1'b0}};
                peak_r  <= {MAG_W{1'b0}};
            end else begin
                count_r <= count_r + 1'b1;
                peak_r  <= pk_s;
            end
        end else begin
            count_r <= count_r;
            peak_r  <= peak_r;
        end
    end

endmodule

// File: rtl/volume_history.sv
// Scrolling volume history for the Speak/Release display: windowed peak level,
// 16-deep bar history and a peak-hold level with timed decay.
module volume_history
    import audio_vis_pkg::*;
#(
    parameter int WINDOW       = 2000,
    parameter int HOLD_WINDOWS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    volume_history_if.slave  bus
);

    localparam int TIMER_W = (HOLD_WINDOWS > 2) ? $clog2(HOLD_WINDOWS) : 1;
    localparam logic [TIMER_W-1:0] LAST_HOLD = TIMER_W'(HOLD_WINDOWS - 1);

    logic               win_close_s;
    level_t             win_level_s;
    level_t             history_r [NUM_BARS];
    level_t             cur_level_r;
    level_t             hold_level_r;
    logic               level_valid_r;
    logic [TIMER_W-1:0] hold_timer_r;
    level_t             hold_next_s;
    logic [TIMER_W-1:0] timer_next_s;

    window_peak_detector #(
        .WINDOW (WINDOW)
    ) u_peak (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (bus.sample_valid),
        .sample       (bus.sample),
        .win_close    (win_close_s),
        .win_level    (win_level_s)
    );

    // Peak hold: a new level at or above the hold refreshes it; otherwise decay one step
    // every HOLD_WINDOWS quiet windows. A hold of 0 always refreshes, so the floor is implicit.
    always_comb begin
        hold_next_s  = hold_level_r;
        timer_next_s = hold_timer_r;
        if (win_close_s) begin
            if (win_level_s >= hold_level_r) begin
                hold_next_s  = win_level_s;
                timer_next_s = {TIMER_W{1'b0}};
            end else if (hold_timer_r == LAST_HOLD) begin
                hold_next_s  = (hold_level_r == 5'd0) ? 5'd0 : hold_level_r - 5'd1;
                timer_next_s = {TIMER_W{1'b0}};
            end else begin
                timer_next_s = hold_timer_r + 1'b1;
            end
        end else begin
            hold_next_s  = hold_level_r;
            timer_next_s = hold_timer_r;
        end
    end

    // Level, pulse and hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_level_r   <= 5'd0;
            level_valid_r <= 1'b0;
            hold_level_r  <= 5'd0;
            hold_timer_r  <= {TIMER_W{1'b0}};
        end else begin
            level_valid_r <= win_close_s;
            hold_level_r  <= hold_next_s;
            hold_timer_r  <= timer_next_s;
            if (win_close_s) begin
                cur_level_r <= win_level_s;
            end else begin
                cur_level_r <= cur_level_r;
            end
        end
    end

    // History shifts toward index 0; freeze only pauses the display, not the measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                history_r[i] <= 5'd0;
            end
        end else if (win_close_s && !bus.freeze) begin
            for (int i = 0; i < NUM_BARS - 1; i++) begin
                history_r[i] <= history_r[i+1];
            end
            history_r[NUM_BARS-1] <= win_level_s;
        end else begin
            for (int i = 0; i < NUM_BARS; i++) begin
                history_r[i] <= history_r[i];
            end
        end
    end

    assign bus.volume      = history_r;
    assign bus.cur_level   = cur_level_r;
    assign bus.hold_level  = hold_level_r;
    assign bus.level_valid = level_valid_r;

endmodule

// File: tb/tb_volume_history.sv
// Directed bench for volume_history with a reference model feeding a scoreboard queue.
module tb_volume_history;
    import audio_vis_pkg::*;

    localparam int WIN   = 4;
    localparam int HOLDW = 2;

    typedef struct packed {
        logic [4:0]  lvl;
        logic [4:0]  hold;
        logic [79:0] vol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    volume_history_if vif();

    volume_history #(.WINDOW(WIN), .HOLD_WINDOWS(HOLDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt, m_peak, m_hold, m_timer;
    int   m_hist[16];

    function automatic logic [79:0] dut_vol();
        logic [79:0] v;
        for (int i = 0; i < 16; i++) v[i*5 +: 5] = vif.volume[i];
        return v;
    endfunction

    function automatic logic [79:0] model_vol();
        logic [79:0] v;
        for (int i = 0; i < 16; i++) v[i*5 +: 5] = m_hist[i][4:0];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_peak = 0; m_hold = 0; m_timer = 0;
        for (int i = 0; i < 16; i++) m_hist[i] = 0;
    endtask

    task automatic model_sample(input int s);
        int   mag, pk, lvl;
        exp_t e;
        mag = (s >= 2048) ? s - 2048 : 2048 - s;
        if (mag > 2047) mag = 2047;
        pk = (mag > m_peak) ? mag : m_peak;
        if (m_cnt == WIN - 1) begin
            lvl = (pk + 64) / 128;
            if (!vif.freeze) begin
                for (int i = 0; i < 15; i++) m_hist[i] = m_hist[i+1];
                m_hist[15] = lvl;
            end
            if (lvl >= m_hold) begin
                m_hold = lvl; m_timer = 0;
            end else if (m_timer == HOLDW - 1) begin
                m_hold = (m_hold > 0) ? m_hold - 1 : 0; m_timer = 0;
            end else begin
                m_timer++;
            end
            e.lvl = lvl[4:0]; e.hold = m_hold[4:0]; e.vol = model_vol();
            sb.push_back(e);
            m_cnt = 0; m_peak = 0;
        end else begin
            m_cnt++; m_peak = pk;
        end
    endtask

    task automatic check_sb();
        exp_t e;
        if (sb.size() > 0) begin
            chk("lv_pulse", vif.level_valid, 1'b1);
            e = sb.pop_front();
            chk("cur_level", vif.cur_level, e.lvl);
            chk("hold_level", vif.hold_level, e.hold);
            chk("volume", dut_vol(), e.vol);
        end else begin
            chk("lv_quiet", vif.level_valid, 1'b0);
        end
    endtask

    // One sample strobe followed by an idle cycle; outputs sampled on falling edges.
    task automatic send(input int s);
        @(negedge clk);
        chk("lv_drop", vif.level_valid, 1'b0);
        vif.sample = s[11:0];
        vif.sample_valid = 1'b1;
        model_sample(s);
        @(negedge clk);
        vif.sample_valid = 1'b0;
        check_sb();
    endtask

    task automatic window4(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    function automatic int lvl_sample(input int l);
        int s;
        s = 2048 + l * 128;
        if (s > 4095) s = 4095;
        return s;
    endfunction

    initial begin
        logic [79:0] exp_v;
        vif.sample_valid = 1'b0;
        vif.sample = 12'd0;
        vif.freeze = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cur", vif.cur_level, 5'd0);
        chk("rst_hold", vif.hold_level, 5'd0);
        chk("rst_lv", vif.level_valid, 1'b0);
        chk("rst_vol", dut_vol(), 80'd0);
        rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("idle_lv", vif.level_valid, 1'b0);
        end
        chk("idle_vol", dut_vol(), 80'd0);

        // 2: first window
        window4(2048, 2048, 2048, 4095);
        chk("s2_cur", vif.cur_level, 5'd16);
        exp_v = 80'd0; exp_v[79:75] = 5'd16;
        chk("s2_vol", dut_vol(), exp_v);

        // 3: saturation, mid level, rounding boundary
        window4(0, 2048, 2048, 2048);
        chk("s3_sat", vif.cur_level, 5'd16);
        window4(2248, 2248, 2248, 2248);
        chk("s3_lvl2", vif.cur_level, 5'd2);
        window4(2111, 2048, 2048, 2048);
        chk("s3_pk63", vif.cur_level, 5'd0);
        window4(2112, 2048, 2048, 2048);
        chk("s3_pk64", vif.cur_level, 5'd1);

        // 4: sweep levels 1..16 then 0
        for (int l = 1; l <= 17; l++) begin
            int s;
            s = (l == 17) ? 2048 : lvl_sample(l);
            window4(2048, s, 2048, 2048);
        end
        for (int i = 0; i < 15; i++) exp_v[i*5 +: 5] = 5'(i + 2);
        exp_v[79:75] = 5'd0;
        chk("s4_vol", dut_vol(), exp_v);

        // 5: freeze and hold decay
        window4(4095, 2048, 2048, 2048);
        chk("s5_hold16", vif.hold_level, 5'd16);
        exp_v = dut_vol();
        vif.freeze = 1'b1;
        window4(2048, 2048, lvl_sample(9), 2048);
        chk("s5_frz_cur", vif.cur_level, 5'd9);
        chk("s5_frz_vol", dut_vol(), model_vol());
        chk("s5_hold_1", vif.hold_level, 5'd16);
        vif.freeze = 1'b0;
        window4(lvl_sample(9), 2048, 2048, 2048);
        chk("s5_hold_15", vif.hold_level, 5'd15);
        window4(2048, 2048, 2048, 2048);
        chk("s5_hold_15b", vif.hold_level, 5'd15);
        window4(2048, 2048, 2048, 2048);
        chk("s5_hold_14", vif.hold_level, 5'd14);

        // 6: reset mid-window discards the partial window
        send(4095); send(4095);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("s6_rst_vol", dut_vol(), 80'd0);
        chk("s6_rst_hold", vif.hold_level, 5'd0);
        rst_n = 1'b1;
        send(2048); send(2048); send(2048);
        send(2048);
        chk("s6_cur", vif.cur_level, 5'd0);
        chk("s6_sb_empty", 80'(sb.size()), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
